gpio_arbiter: RTL
=================

GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data width on all ports, matching the shared GPIO port.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the number of stalled strobe cycles before a bus error (legal range 2..65535).
REQ-003 SHALL have port wb_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports m0_adr_i / m1_adr_i, input, 32 bits: master address.
REQ-006 SHALL have ports m0_dat_i / m1_dat_i, input, WIDTH bits: master write data.
REQ-007 SHALL have ports m0_we_i, m0_cyc_i, m0_stb_i (and m1_ equivalents), input, 1 bit each: master write enable, cycle, strobe.
REQ-008 SHALL have ports m0_dat_o / m1_dat_o, output, WIDTH bits: read data returned to the master.
REQ-009 SHALL have ports m0_ack_o, m0_err_o (and m1_ equivalents), output, 1 bit each: master acknowledge and error.
REQ-010 SHALL have port s_adr_o, output, 32 bits, and s_dat_o, output, WIDTH bits: slave address and write data.
REQ-011 SHALL have ports s_we_o, s_cyc_o, s_stb_o, output, 1 bit each: slave write enable, cycle, strobe.
REQ-012 SHALL have ports s_dat_i, input, WIDTH bits, and s_ack_i, s_err_i, input, 1 bit each: slave read data, acknowledge, error.
REQ-013 SHALL have port gnt_o, output, 2 bits: one-hot current grant, 00 when idle (for debug and irq routing).

Function
REQ-014 SHALL implement states IDLE, GNT0, GNT1 held in registers; the grant SHALL change only on a clock edge.
REQ-015 IDLE: if exactly one mX_cyc_i is high, the next state SHALL be GNTX; if both are high, the next state SHALL be GNT(prio); if neither is high, the state SHALL remain IDLE.
REQ-016 prio SHALL be a 1-bit round-robin pointer; on leaving GNTX, prio SHALL become the other master.
REQ-017 GNTX SHALL persist while mX_cyc_i is high; when mX_cyc_i is low, the next state SHALL be IDLE. The other master SHALL never preempt, and there SHALL be a minimum of one IDLE cycle between grants.
REQ-018 Arbitration latency SHALL be 1 cycle: a cyc asserted in IDLE at edge N is forwarded to the slave from edge N+1.
REQ-019 In GNTX, s_adr_o, s_dat_o, s_we_o, and s_cyc_o SHALL combinationally follow master X.
REQ-020 In GNTX, s_stb_o SHALL equal mX_stb_i & ~to_err.
REQ-021 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and s_adr_o, s_dat_o, s_we_o SHALL be 0.
REQ-022 In GNTX, mX_ack_o SHALL equal s_ack_i & mX_stb_i; this path is combinational.
REQ-023 mX_dat_o SHALL equal s_dat_i for the granted master and 0 otherwise.
REQ-024 The non-granted master SHALL see ack=0, err=0.
REQ-025 A 16-bit stall counter SHALL reset to 0 when in IDLE, when the granted stb is low, or on s_ack_i or s_err_i; otherwise it SHALL increment.
REQ-026 When the counter equals TIMEOUT-1 without ack, register to_err SHALL be set for exactly one cycle and the counter SHALL clear.
REQ-027 mX_err_o SHALL equal (s_err_i & mX_stb_i) | to_err for the granted master.
REQ-028 The grant SHALL be retained after a timeout until the master drops cyc.
REQ-029 s_ack_i and s_err_i arriving while in IDLE SHALL be ignored.
REQ-030 gnt_o SHALL be 2'b01 in GNT0, 2'b10 in GNT1, and 2'b00 in IDLE.

Reset
REQ-031 When wb_rst is high at a clock edge, the state SHALL become IDLE, prio SHALL become 0, the counter SHALL become 0, and to_err SHALL become 0.
REQ-032 After reset, all s_* outputs, all m*_ack_o, m*_err_o, and m*_dat_o SHALL be 0, and gnt_o SHALL be 00.
REQ-033 Reset mid-transfer SHALL drop the grant on the same edge, with no ack or err issued to either master.
REQ-034 Reset SHALL take priority over all other events.

Verification
REQ-035 Release reset, then raise m0_cyc/stb with a write to 0x00 of 8'hA5 -> gnt_o=01 after 1 cycle; s_adr_o=0x00, s_dat_o=A5, s_we_o=1; m0_ack_o mirrors s_ack_i.
REQ-036 Both cyc high in IDLE after reset -> GNT0. After m0 drops cyc and both request again -> IDLE for 1 cycle, then GNT1. Repeat -> GNT0 (alternation).
REQ-037 m1 read of 0x04 while m0 holds cyc -> m1 sees no ack and s_adr_o stays on m0's address; m1 is granted 2 cycles after m0 drops cyc; m1_dat_o returns the slave's 8'h0F.
REQ-038 With TIMEOUT=4 and the slave never acking -> m0_err_o pulses for 1 cycle on the 4th stalled cycle, s_stb_o is low that cycle, and gnt_o stays 01 until m0 drops cyc.
REQ-039 Assert wb_rst during GNT1 with stb high -> next edge gnt_o=00, s_cyc_o=0, and m1_ack_o/m1_err_o are never asserted.
REQ-040 s_ack_i is forced high while IDLE -> both mX_ack_o remain 0.

Source files
------------

// File: rtl/gpio_arbiter.sv
// Two-master Wishbone arbiter for the shared GPIO port.
// It uses round-robin grant with no preemption and a bus-error timeout on stalled strobes.
//
// state | meaning
// IDLE  | no grant; slave bus driven to zero; slave ack/err ignored
// GNT0  | master 0 owns the slave bus until it drops cyc
// GNT1  | master 1 owns the slave bus until it drops cyc
module gpio_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk,
  input  logic             wb_rst,

  input  logic [31:0]      m0_adr_i,
  input  logic [WIDTH-1:0] m0_dat_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [WIDTH-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,

  input  logic [31:0]      m1_adr_i,
  input  logic [WIDTH-1:0] m1_dat_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [WIDTH-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,

  output logic [31:0]      s_adr_o,
  output logic [WIDTH-1:0] s_dat_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [WIDTH-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,

  output logic [1:0]       gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // to_err is registered, so it is set one edge early. This makes the error
  // visible during the TIMEOUT-th stalled cycle.
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 2);

  state_t      state, state_nxt;
  logic        prio, prio_nxt;
  logic [15:0] stall_cnt;
  logic        to_err;

  logic [31:0]      g_adr;
  logic [WIDTH-1:0] g_dat;
  logic             g_we;
  logic             g_cyc;
  logic             g_stb;
  logic             stalled;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = prio ? GNT1 : GNT0;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b1;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    case (state)
      GNT0: begin
        g_adr = m0_adr_i;
        g_dat = m0_dat_i;
        g_we  = m0_we_i;
        g_cyc = m0_cyc_i;
        g_stb = m0_stb_i;
      end
      GNT1: begin
        g_adr = m1_adr_i;
        g_dat = m1_dat_i;
        g_we  = m1_we_i;
        g_cyc = m1_cyc_i;
        g_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_we_o  = g_we;
  assign s_cyc_o = g_cyc;
  assign s_stb_o = g_stb & ~to_err;

  assign stalled = (state != IDLE) && g_stb && !s_ack_i && !s_err_i && !to_err;

  // The counter is held clear through the error cycle, so a persistent stall errors again after TIMEOUT cycles.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      stall_cnt <= 16'd0;
      to_err    <= 1'b0;
    end else if (!stalled) begin
      stall_cnt <= 16'd0;
      to_err    <= 1'b0;
    end else if (stall_cnt == STALL_LIMIT && g_cyc) begin
      stall_cnt <= 16'd0;
      to_err    <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + 16'd1;
      to_err    <= 1'b0;
    end
  end

  always_comb begin
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = (s_err_i & m0_stb_i) | to_err;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = (s_err_i & m1_stb_i) | to_err;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
